// File: rtl/fifo_rd_arbiter.sv
// Round-robin read arbiter in front of a FIFO read port: grants one requester at a time
// and streams up to burst_len words to it, one per cycle, straight from the FIFO read data.
module fifo_rd_arbiter #(
  parameter int NREQ     = 4,
  parameter int DATASIZE = 8,
  parameter int BURST_W  = 4
) (
  input  logic                    rclk,
  input  logic                    rrst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [BURST_W-1:0]      burst_len,
  input  logic                    rempty,
  input  logic [DATASIZE-1:0]     rdata,
  output logic                    rinc,
  output logic [NREQ-1:0]         gnt,
  output logic [DATASIZE-1:0]     dout,
  output logic                    dout_valid,
  output logic [$clog2(NREQ)-1:0] dout_id,
  output logic                    burst_done,
  output logic                    busy
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] READ  = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [IDW-1:0]     last_winner;
  logic [IDW-1:0]     winner;
  logic [IDW-1:0]     rr_pick;
  logic               rr_found;
  logic [BURST_W-1:0] count;
  logic               owner_req;
  logic               last_word;
  logic               exit_read;

  // Round-robin search starting just above the previous winner, wrapping around.
  // NOTE: every always_comb output is given a default first, so no path can infer a latch.
  always_comb begin
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!rr_found && req[(int'(last_winner) + i) % NREQ]) begin
        rr_pick  = IDW'((int'(last_winner) + i) % NREQ);
        rr_found = 1'b1;
      end
    end
  end

  assign owner_req = req[winner];

  // rinc is gated by reset so an in-flight burst cannot pop in the cycle reset is sampled.
  assign rinc       = rrst_n && (state == READ) && owner_req && !rempty;
  assign last_word  = rinc && (count == BURST_W'(1));
  assign exit_read  = (state == READ) && (last_word || !owner_req || rempty);
  assign burst_done = rrst_n && exit_read;

  assign dout_valid = rinc;
  assign dout       = rdata;
  assign dout_id    = winner;
  assign busy       = (state != IDLE);

  always_comb begin
    gnt = '0;
    if (state == GRANT && rr_found) gnt = NREQ'(1) << rr_pick;
    else if (state == READ)         gnt = NREQ'(1) << winner;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req && !rempty) state_nxt = GRANT;
      GRANT:   state_nxt = rr_found ? READ : IDLE;
      READ:    if (exit_read) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state       <= IDLE;
      last_winner <= IDW'(NREQ - 1);
      winner      <= '0;
      count       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        GRANT: begin
          if (rr_found) begin
            winner <= rr_pick;
            count  <= (burst_len == '0) ? BURST_W'(1) : burst_len;
          end
        end
        READ: begin
          if (rinc)      count       <= count - BURST_W'(1);
          if (exit_read) last_winner <= winner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: a queue models the FIFO, a scoreboard holds the
// expected (requester, data) words in delivery order.
module tb_fifo_rd_arbiter;

  localparam int NREQ     = 4;
  localparam int DATASIZE = 8;
  localparam int BURST_W  = 4;
  localparam int IDW      = 2;

  logic                rclk = 1'b0;
  logic                rrst_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [BURST_W-1:0]  burst_len = '0;
  logic                rempty = 1'b1;
  logic [DATASIZE-1:0] rdata = '0;
  logic                rinc;
  logic [NREQ-1:0]     gnt;
  logic [DATASIZE-1:0] dout;
  logic                dout_valid;
  logic [IDW-1:0]      dout_id;
  logic                burst_done;
  logic                busy;

  fifo_rd_arbiter #(.NREQ(NREQ), .DATASIZE(DATASIZE), .BURST_W(BURST_W)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .req(req), .burst_len(burst_len),
    .rempty(rempty), .rdata(rdata), .rinc(rinc), .gnt(gnt), .dout(dout),
    .dout_valid(dout_valid), .dout_id(dout_id), .burst_done(burst_done), .busy(busy)
  );

  always #5 rclk = ~rclk;

  typedef struct packed {
    logic [IDW-1:0]      id;
    logic [DATASIZE-1:0] data;
  } word_t;

  logic [DATASIZE-1:0] fifo[$];
  word_t               sb[$];
  int                  vcyc[$];
  int                  done_at[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, n_words = 0, n_done = 0, n_done_word = 0;
  logic                pop_pend = 1'b0;
  logic [NREQ-1:0]     o_gnt;
  logic                o_done, o_busy, o_valid, o_rinc;
  logic [IDW-1:0]      o_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sync_fifo();
    rempty = (fifo.size() == 0);
    rdata  = rempty ? '0 : fifo[0];
  endtask

  task automatic load(input int n, input logic [DATASIZE-1:0] base);
    for (int i = 0; i < n; i++) fifo.push_back(base + DATASIZE'(i));
    sync_fifo();
  endtask

  task automatic expect_word(input logic [IDW-1:0] id, input logic [DATASIZE-1:0] data);
    word_t w;
    w.id   = id;
    w.data = data;
    sb.push_back(w);
  endtask

  task automatic reset_counts();
    n_words = 0; n_done = 0; n_done_word = 0;
    vcyc.delete(); done_at.delete();
  endtask

  // Observe one cycle at the falling edge, then advance past the rising edge and update the FIFO model.
  task automatic tick();
    word_t w;
    @(negedge rclk);
    cyc++;
    o_gnt = gnt; o_done = burst_done; o_busy = busy;
    o_valid = dout_valid; o_rinc = rinc; o_id = dout_id;
    if (rempty) chk("rinc_while_empty", 32'(rinc), 0);
    if (dout_valid) begin
      n_words++;
      vcyc.push_back(cyc);
      if (sb.size() == 0) chk("unexpected_word", 32'(dout_valid), 0);
      else begin
        w = sb.pop_front();
        chk("dout", 32'(dout), 32'(w.data));
        chk("dout_id", 32'(dout_id), 32'(w.id));
        chk("gnt_owner", 32'(gnt), 32'(NREQ'(1) << w.id));
      end
    end
    if (burst_done) begin
      n_done++;
      done_at.push_back(n_words);
      if (dout_valid) n_done_word++;
    end
    pop_pend = rinc;
    @(posedge rclk);
    #1;
    if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
    pop_pend = 1'b0;
    sync_fifo();
  endtask

  task automatic run_words(input int target, input int budget, input string tag);
    int k = 0;
    while (n_words < target && k < budget) begin tick(); k++; end
    chk({tag, "_words"}, 32'(n_words), 32'(target));
  endtask

  task automatic run_done(input int target, input int budget, input string tag);
    int k = 0;
    while (n_done < target && k < budget) begin tick(); k++; end
    chk({tag, "_bursts"}, 32'(n_done), 32'(target));
  endtask

  task automatic drain();
    req = '0;
    tick(); tick();
    fifo.delete();
    sync_fifo();
  endtask

  initial begin
    int rel;
    sync_fifo();
    repeat (2) tick();
    chk("rst_gnt", 32'(o_gnt), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_rinc", 32'(o_rinc), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_id", 32'(o_id), 0);

    // Single requester, burst of 3 then 2 words ending on empty.
    reset_counts();
    load(5, 8'h10);
    for (int i = 0; i < 5; i++) expect_word(2'd0, 8'h10 + DATASIZE'(i));
    req = 4'b0001; burst_len = 4'd3;
    rrst_n = 1'b1;
    rel = cyc + 1;
    run_words(5, 40, "single");
    run_done(2, 10, "single");
    chk("latency", 32'(vcyc[0] - rel), 2);
    chk("back_to_back", 32'(vcyc[2] - vcyc[0]), 2);
    chk("burst_gap", 32'(vcyc[3] - vcyc[2]), 3);
    chk("done_at_word3", 32'(done_at[0]), 3);
    chk("done_at_empty", 32'(done_at[1]), 5);
    chk("done_with_word", 32'(n_done_word), 1);
    drain();
    chk("single_idle_busy", 32'(o_busy), 0);
    chk("single_idle_gnt", 32'(o_gnt), 0);

    // Round robin after reset: 0,1,2,3,0 with burst_len 1.
    rrst_n = 1'b0; tick(); rrst_n = 1'b1;
    reset_counts();
    load(20, 8'h40);
    expect_word(2'd0, 8'h40); expect_word(2'd1, 8'h41); expect_word(2'd2, 8'h42);
    expect_word(2'd3, 8'h43); expect_word(2'd0, 8'h44);
    req = 4'b1111; burst_len = 4'd1;
    run_words(5, 60, "rr");
    req = '0;
    for (int i = 1; i < 5; i++) chk("rr_gap", 32'(vcyc[i] - vcyc[i-1]), 3);
    chk("rr_bursts", 32'(n_done), 5);
    drain();

    // Empty mid-burst: burst_len 8, only 2 words available.
    reset_counts();
    load(2, 8'h80);
    expect_word(2'd0, 8'h80); expect_word(2'd0, 8'h81);
    req = 4'b0001; burst_len = 4'd8;
    run_done(1, 20, "empty");
    chk("empty_words", 32'(n_words), 2);
    chk("empty_done_no_word", 32'(n_done_word), 0);
    tick();
    chk("empty_idle_busy", 32'(o_busy), 0);
    drain();

    // Reset during a burst owned by requester 1; next grant must go to requester 0.
    reset_counts();
    load(6, 8'hC0);
    expect_word(2'd1, 8'hC0);
    req = 4'b1111; burst_len = 4'd4;
    run_words(1, 20, "rstmid");
    rrst_n = 1'b0;
    tick();
    chk("rstmid_rinc", 32'(o_rinc), 0);
    chk("rstmid_valid", 32'(o_valid), 0);
    chk("rstmid_done", 32'(o_done), 0);
    tick();
    chk("rstmid_busy", 32'(o_busy), 0);
    chk("rstmid_gnt", 32'(o_gnt), 0);
    rrst_n = 1'b1; burst_len = 4'd1;
    expect_word(2'd0, 8'hC1);
    run_words(2, 20, "rstmid_after");
    chk("rstmid_bursts", 32'(n_done), 1);
    drain();

    // Requester 2 drops after one word; the following grant must go to requester 3.
    reset_counts();
    load(6, 8'hA0);
    expect_word(2'd2, 8'hA0);
    req = 4'b0100; burst_len = 4'd4;
    run_words(1, 20, "drop");
    req = '0;
    tick();
    chk("drop_done", 32'(o_done), 1);
    chk("drop_no_rinc", 32'(o_rinc), 0);
    tick();
    chk("drop_busy", 32'(o_busy), 0);
    chk("drop_gnt", 32'(o_gnt), 0);
    burst_len = 4'd1; req = 4'b1111;
    expect_word(2'd3, 8'hA1);
    run_words(2, 20, "drop_next");
    drain();

    // burst_len 0 acts as 1: each grant carries exactly one word.
    reset_counts();
    load(3, 8'hE0);
    expect_word(2'd1, 8'hE0); expect_word(2'd1, 8'hE1);
    req = 4'b0010; burst_len = 4'd0;
    run_done(2, 30, "bl0");
    chk("bl0_words", 32'(n_words), 2);
    chk("bl0_done_with_word", 32'(n_done_word), 2);
    drain();

    chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
